sfifo_prog: RTL and testbench
=============================

SFIFO_PROG -- requirements
Module: sfifo_prog
Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits.
REQ-002 Parameter: DEPTH, 16, entry count; SHALL be a power of two >= 4.
REQ-003 Parameter: CWIDTH, 4, log2(DEPTH); pointer width.
REQ-004 Parameter: AFULL_THR, DEPTH-4, almost-full threshold, 1..DEPTH-1.
REQ-005 Parameter: AEMPTY_THR, 2, almost-empty threshold, 0..DEPTH-2, < AFULL_THR.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous reset, active-high.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 i_wreq  input  1  write request.
REQ-010 o_wready  output  1  write accepted this cycle if i_wreq; equals !fifo_isfull.
REQ-011 i_rreq  input  1  read request.
REQ-012 o_rready  output  1  read accepted this cycle if i_rreq; equals !fifo_isempty.
REQ-013 rdata  output  WIDTH  read data.
REQ-014 o_rvalid  output  1  rdata holds a valid popped/head word.
REQ-015 fifo_isfull / fifo_isempty  output  1 each  count==DEPTH / count==0.
REQ-016 fifo_afull / fifo_aempty  output  1 each  count>=AFULL_THR / count<=AEMPTY_THR.
REQ-017 fifo_count  output  CWIDTH+1  current occupancy, 0..DEPTH.
REQ-018 o_overflow / o_underflow  output  1 each  sticky error flags.
Function
REQ-019 Write accept = i_wreq && !fifo_isfull: mem[wr_ptr]<=wdata, wr_ptr+1.
REQ-020 Read accept = i_rreq && !fifo_isempty: rd_ptr+1.
REQ-021 Pointers SHALL wrap DEPTH-1 -> 0 via natural CWIDTH-bit overflow.
REQ-022 fifo_count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-023 Full + i_wreq + i_rreq: read accepted, write refused, count -> DEPTH-1.
REQ-024 Empty + i_wreq + i_rreq: write accepted, read refused, count -> 1 (both modes).
REQ-025 All flags and fifo_count SHALL be registered, computed from next-state count, updating in the same cycle as count.
REQ-026 i_wreq while full SHALL set o_overflow; i_rreq while empty SHALL set o_underflow; both hold until reset; FIFO state unaffected.
REQ-027 Refused requests SHALL not modify memory, pointers, count or rdata.
Reset
REQ-028 reset sampled high at clk edge: wr_ptr=rd_ptr=0, fifo_count=0, fifo_isempty=1, fifo_aempty=1, fifo_isfull=0, fifo_afull=0, o_wready=1, o_rready=0, o_rvalid=0, rdata=0, o_overflow=o_underflow=0.
REQ-029 Memory array SHALL not be reset; reset mid-operation discards all contents, asserted reset overrides any simultaneous request.
Configuration
REQ-030 Macro SFIFO_FWFT_EN selects read mode.
REQ-031 Without SFIFO_FWFT_EN: accepted read at edge N SHALL present mem[rd_ptr] on rdata with o_rvalid=1 after edge N (1-cycle latency); o_rvalid=0 after edges with no accepted read; rdata holds last value.
REQ-032 With SFIFO_FWFT_EN: rdata SHALL show head word and o_rvalid SHALL equal !fifo_isempty, zero latency; i_rreq acknowledges/pops the displayed word; first write to empty FIFO visible on rdata the cycle after the write edge.
Verification (WIDTH=8, DEPTH=16, AFULL_THR=12, AEMPTY_THR=2)
REQ-033 Reset, write 0x01..0x10 -> fifo_count=16, fifo_isfull=1, o_wready=0, fifo_afull set after 12th write, fifo_aempty clear after 3rd write.
REQ-034 Full, 17th write 0xAA -> o_overflow=1 sticky, count stays 16; drain 16 -> data 0x01..0x10 in order, fifo_isempty=1.
REQ-035 Count=5, i_wreq+i_rreq for 40 cycles -> count stays 5, pointers wrap twice, data order preserved.
REQ-036 Empty, i_rreq alone -> o_underflow=1, no rvalid; empty + i_wreq(0x5A)+i_rreq -> count=1, 0x5A read next.
REQ-037 Count=9, reset asserted for one cycle with i_wreq high -> all outputs at REQ-028 values, count=0.
REQ-038 Both macro settings: write 0x3C into empty -> FWFT: rdata=0x3C, o_rvalid=1 next cycle without i_rreq; non-FWFT: rdata=0x3C one cycle after accepted read.

Source files
------------

// File: rtl/sfifo_prog.sv
// Synchronous FIFO with registered occupancy flags and sticky error flags.
// Define SFIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle read latency.
module sfifo_prog #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int CWIDTH     = 4,
  parameter int AFULL_THR  = DEPTH - 4,
  parameter int AEMPTY_THR = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              i_wreq,
  output logic              o_wready,
  input  logic              i_rreq,
  output logic              o_rready,
  output logic [WIDTH-1:0]  rdata,
  output logic              o_rvalid,
  output logic              fifo_isfull,
  output logic              fifo_isempty,
  output logic              fifo_afull,
  output logic              fifo_aempty,
  output logic [CWIDTH:0]   fifo_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [CWIDTH:0] CNT_FULL = (CWIDTH+1)'(DEPTH);
  localparam logic [CWIDTH:0] CNT_AF   = (CWIDTH+1)'(AFULL_THR);
  localparam logic [CWIDTH:0] CNT_AE   = (CWIDTH+1)'(AEMPTY_THR);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [CWIDTH-1:0] wr_ptr;
  logic [CWIDTH-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [CWIDTH:0]   cnt_nxt;

  assign wr_acc = i_wreq && !fifo_isfull;
  assign rd_acc = i_rreq && !fifo_isempty;

  always_comb begin
    cnt_nxt = fifo_count;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = fifo_count + 1'b1;
      2'b01:   cnt_nxt = fifo_count - 1'b1;
      default: cnt_nxt = fifo_count;
    endcase
  end

  // Flags come from the next count so they change on the same edge as it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_isfull  <= 1'b0;
      fifo_isempty <= 1'b1;
      fifo_afull   <= 1'b0;
      fifo_aempty  <= 1'b1;
      o_wready     <= 1'b1;
      o_rready     <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      fifo_count   <= cnt_nxt;
      fifo_isfull  <= (cnt_nxt == CNT_FULL);
      fifo_isempty <= (cnt_nxt == '0);
      fifo_afull   <= (cnt_nxt >= CNT_AF);
      fifo_aempty  <= (cnt_nxt <= CNT_AE);
      o_wready     <= (cnt_nxt != CNT_FULL);
      o_rready     <= (cnt_nxt != '0);
      if (i_wreq && fifo_isfull)  o_overflow  <= 1'b1;
      if (i_rreq && fifo_isempty) o_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr] <= wdata;
  end

`ifdef SFIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty.
  assign rdata    = fifo_isempty ? '0 : mem[rd_ptr];
  assign o_rvalid = !fifo_isempty;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= rd_acc;
      if (rd_acc) rdata <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_prog.sv
// Self-checking bench for sfifo_prog against a queue-based reference model.
// Directed scenarios followed by a randomized phase.
module tb_sfifo_prog;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int CWIDTH = 4;
  localparam int AFT    = 12;
  localparam int AET    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  wdata;
  logic              i_wreq;
  logic              o_wready;
  logic              i_rreq;
  logic              o_rready;
  logic [WIDTH-1:0]  rdata;
  logic              o_rvalid;
  logic              fifo_isfull;
  logic              fifo_isempty;
  logic              fifo_afull;
  logic              fifo_aempty;
  logic [CWIDTH:0]   fifo_count;
  logic              o_overflow;
  logic              o_underflow;

  sfifo_prog #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CWIDTH(CWIDTH),
    .AFULL_THR(AFT), .AEMPTY_THR(AET)
  ) dut (
    .clk(clk), .reset(reset), .wdata(wdata),
    .i_wreq(i_wreq), .o_wready(o_wready),
    .i_rreq(i_rreq), .o_rready(o_rready),
    .rdata(rdata), .o_rvalid(o_rvalid),
    .fifo_isfull(fifo_isfull), .fifo_isempty(fifo_isempty),
    .fifo_afull(fifo_afull), .fifo_aempty(fifo_aempty),
    .fifo_count(fifo_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf;
  logic             m_unf;
  logic [WIDTH-1:0] m_rdata;
  logic             m_rvalid;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",  int'(fifo_count),   n);
    chk("full",   int'(fifo_isfull),  int'(n == DEPTH));
    chk("empty",  int'(fifo_isempty), int'(n == 0));
    chk("afull",  int'(fifo_afull),   int'(n >= AFT));
    chk("aempty", int'(fifo_aempty),  int'(n <= AET));
    chk("wready", int'(o_wready),     int'(n != DEPTH));
    chk("rready", int'(o_rready),     int'(n != 0));
    chk("ovf",    int'(o_overflow),   int'(m_ovf));
    chk("unf",    int'(o_underflow),  int'(m_unf));
`ifdef SFIFO_FWFT_EN
    chk("rvalid", int'(o_rvalid), int'(n != 0));
    chk("rdata",  int'(rdata),    (n != 0) ? int'(q[0]) : 0);
`else
    chk("rvalid", int'(o_rvalid), int'(m_rvalid));
    chk("rdata",  int'(rdata),    int'(m_rdata));
`endif
  endtask

  task automatic step(input logic rst, input logic wr,
                      input logic rd, input logic [WIDTH-1:0] d);
    bit was_full;
    bit was_empty;
    reset  = rst;
    i_wreq = wr;
    i_rreq = rd;
    wdata  = d;
    @(posedge clk);
    cyc++;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdata = '0; m_rvalid = 0;
    end else begin
      if (wr && was_full)  m_ovf = 1;
      if (rd && was_empty) m_unf = 1;
      m_rvalid = 0;
      if (rd && !was_empty) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1;
      end
      if (wr && !was_full) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    q.delete();
    m_ovf = 0; m_unf = 0; m_rdata = '0; m_rvalid = 0;
    reset = 1; i_wreq = 0; i_rreq = 0; wdata = '0;

    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'hFF);

    for (int i = 1; i <= 16; i++) step(0, 1, 0, 8'(i));
    chk("fill_count", int'(fifo_count), 16);

    step(0, 1, 0, 8'hAA);
    chk("ovf_set", int'(o_overflow), 1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 8'h00);
`ifndef SFIFO_FWFT_EN
      chk("drain_order", int'(rdata), i);
`endif
    end
    step(0, 0, 0, 8'h00);

    step(0, 0, 1, 8'h00);
    chk("unf_set", int'(o_underflow), 1);
    step(0, 1, 1, 8'h5A);
    chk("empty_both", int'(fifo_count), 1);
    step(0, 0, 1, 8'h00);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(0, 1, 1, 8'($urandom));
    chk("steady5", int'(fifo_count), 5);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'($urandom));
    step(1, 1, 0, 8'h77);
    chk("rst_count", int'(fifo_count), 0);

    step(0, 1, 0, 8'h3C);
    step(0, 0, 0, 8'h00);
`ifdef SFIFO_FWFT_EN
    chk("fwft_3c", int'(rdata), 8'h3C);
`endif
    step(0, 0, 1, 8'h00);
`ifndef SFIFO_FWFT_EN
    chk("nfwft_3c", int'(rdata), 8'h3C);
`endif
    step(0, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
           8'($urandom));
    end
    for (int i = 0; i < 20; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
